// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the memory-access stage and a 32-bit block RAM.
// Define LSU_ERR_EN to enable misaligned/reserved-size error responses and the WAIT timeout.
module mem_lsu #(
    parameter int AW      = 13,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rd_data,
    input  logic          mem_rd_valid,
    output logic          mem_wr_en,
    output logic [31:0]   mem_wr_data,
    output logic [3:0]    mem_wr_mask
);
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Store and error responses are registered straight out of IDLE, so only loads
    // occupy extra states and only loads drop req_ready.
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

    state_t        state_reg, state_next;
    logic [1:0]    size_reg, size_next;
    logic          uns_reg, uns_next;
    logic [1:0]    lane_reg, lane_next;
    logic          resp_valid_reg, resp_valid_next;
    logic          resp_err_reg, resp_err_next;
    logic [31:0]   resp_rdata_reg, resp_rdata_next;
    logic          mem_rd_en_reg, mem_rd_en_next;
    logic          mem_wr_en_reg, mem_wr_en_next;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic [31:0]   mem_wr_data_reg, mem_wr_data_next;
    logic [3:0]    mem_wr_mask_reg, mem_wr_mask_next;
`ifdef LSU_ERR_EN
    logic [7:0]    cnt_reg, cnt_next;
`endif

    logic [1:0]    lane;
    logic          req_err;
    logic [31:0]   st_data;
    logic [3:0]    st_mask;
    logic [7:0]    rd_byte [4];
    logic [7:0]    ld_b;
    logic [15:0]   ld_h;
    logic [31:0]   ld_data;

    assign lane      = req_addr[1:0];
    assign req_ready = rst_n && (state_reg == S_IDLE);

`ifdef LSU_ERR_EN
    assign req_err = (req_size == 2'd3) ||
                     (req_size == SZ_HALF && lane[0]) ||
                     (req_size == SZ_WORD && lane != 2'b00);
`else
    assign req_err = 1'b0;
`endif

    // Mask bit (3-k) enables byte lane k; misaligned low bits simply fall away.
    always_comb begin
        st_data = req_wdata;
        st_mask = 4'b1111;
        case (req_size)
            SZ_BYTE: begin
                st_data = {4{req_wdata[7:0]}};
                st_mask = 4'b1000 >> lane;
            end
            SZ_HALF: begin
                st_data = {2{req_wdata[15:0]}};
                st_mask = lane[1] ? 4'b0011 : 4'b1100;
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_byte[gi] = mem_rd_data[8*gi +: 8];
    end

    always_comb begin
        ld_b = rd_byte[lane_reg];
        ld_h = {rd_byte[{lane_reg[1], 1'b1}], rd_byte[{lane_reg[1], 1'b0}]};
        case (size_reg)
            SZ_BYTE: ld_data = {{24{ld_b[7] & ~uns_reg}}, ld_b};
            SZ_HALF: ld_data = {{16{ld_h[15] & ~uns_reg}}, ld_h};
            default: ld_data = mem_rd_data;
        endcase
    end

    always_comb begin
        state_next       = state_reg;
        size_next        = size_reg;
        uns_next         = uns_reg;
        lane_next        = lane_reg;
        resp_valid_next  = 1'b0;
        resp_err_next    = 1'b0;
        resp_rdata_next  = resp_rdata_reg;
        mem_rd_en_next   = 1'b0;
        mem_wr_en_next   = 1'b0;
        mem_addr_next    = mem_addr_reg;
        mem_wr_data_next = mem_wr_data_reg;
        mem_wr_mask_next = mem_wr_mask_reg;
`ifdef LSU_ERR_EN
        cnt_next         = cnt_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    size_next = req_size;
                    uns_next  = req_unsigned;
                    lane_next = lane;
                    if (req_err) begin
                        resp_valid_next = 1'b1;
                        resp_err_next   = 1'b1;
                        resp_rdata_next = 32'd0;
                    end else if (req_we) begin
                        mem_wr_en_next   = 1'b1;
                        mem_addr_next    = {req_addr[AW-1:2], 2'b00};
                        mem_wr_data_next = st_data;
                        mem_wr_mask_next = st_mask;
                        resp_valid_next  = 1'b1;
                        resp_rdata_next  = 32'd0;
                    end else begin
                        mem_rd_en_next = 1'b1;
                        mem_addr_next  = {req_addr[AW-1:2], 2'b00};
                        state_next     = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                state_next = S_WAIT;
`ifdef LSU_ERR_EN
                cnt_next   = 8'd0;
`endif
            end
            S_WAIT: begin
                if (mem_rd_valid) begin
                    resp_valid_next = 1'b1;
                    resp_rdata_next = ld_data;
                    state_next      = S_IDLE;
                end
`ifdef LSU_ERR_EN
                // cnt_reg holds the WAIT cycles already spent before this one.
                else if (TIMEOUT != 0 && cnt_reg == 8'(TIMEOUT - 1)) begin
                    resp_valid_next = 1'b1;
                    resp_err_next   = 1'b1;
                    resp_rdata_next = 32'd0;
                    state_next      = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
`endif
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            size_reg        <= 2'd0;
            uns_reg         <= 1'b0;
            lane_reg        <= 2'd0;
            resp_valid_reg  <= 1'b0;
            resp_err_reg    <= 1'b0;
            resp_rdata_reg  <= 32'd0;
            mem_rd_en_reg   <= 1'b0;
            mem_wr_en_reg   <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wr_data_reg <= 32'd0;
            mem_wr_mask_reg <= 4'd0;
`ifdef LSU_ERR_EN
            cnt_reg         <= 8'd0;
`endif
        end else begin
            state_reg       <= state_next;
            size_reg        <= size_next;
            uns_reg         <= uns_next;
            lane_reg        <= lane_next;
            resp_valid_reg  <= resp_valid_next;
            resp_err_reg    <= resp_err_next;
            resp_rdata_reg  <= resp_rdata_next;
            mem_rd_en_reg   <= mem_rd_en_next;
            mem_wr_en_reg   <= mem_wr_en_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wr_data_reg <= mem_wr_data_next;
            mem_wr_mask_reg <= mem_wr_mask_next;
`ifdef LSU_ERR_EN
            cnt_reg         <= cnt_next;
`endif
        end
    end

    assign resp_valid  = resp_valid_reg;
    assign resp_err    = resp_err_reg;
    assign resp_rdata  = resp_rdata_reg;
    assign mem_rd_en   = mem_rd_en_reg;
    assign mem_wr_en   = mem_wr_en_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wr_data = mem_wr_data_reg;
    assign mem_wr_mask = mem_wr_mask_reg;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: a byte-array reference model predicts strobes and
// responses; a fake RAM answers reads; a negedge monitor compares in order.
`timescale 1ns/1ps
module tb_mem_lsu;
    localparam int AW      = 13;
    localparam int TIMEOUT = 15;
    localparam int SPAN    = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    logic          mem_rd_en, mem_wr_en, mem_rd_valid;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rd_data, mem_wr_data;
    logic [3:0]    mem_wr_mask;

    mem_lsu #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_rd_valid(mem_rd_valid), .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Fake RAM: answers a read one cycle after mem_rd_en and applies masked writes.
    logic          rd_resp_en;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic          inj_valid;
    logic [31:0]   inj_data;
    logic          init_we;
    logic [4:0]    init_idx;
    logic [31:0]   init_word;
    logic [31:0]   ram [SPAN/4];

    assign mem_rd_valid = rsp_valid | inj_valid;
    assign mem_rd_data  = inj_valid ? inj_data : rsp_data;

    always @(posedge clk) begin
        rsp_valid <= rd_resp_en && mem_rd_en;
        rsp_data  <= ram[mem_addr[6:2]];
        if (init_we) ram[init_idx] <= init_word;
        if (mem_wr_en)
            for (int k = 0; k < 4; k++)
                if (mem_wr_mask[3-k]) ram[mem_addr[6:2]][8*k +: 8] <= mem_wr_data[8*k +: 8];
    end

    // Reference model: plain byte-addressed memory plus expectation queues.
    typedef struct { int cyc; logic [31:0] rdata; logic err; } resp_t;
    typedef struct { int cyc; logic [AW-1:0] addr; logic [31:0] data; logic [3:0] mask; } wr_t;
    typedef struct { int cyc; logic [AW-1:0] addr; } rd_t;

    logic [7:0] model_mem [SPAN];
    resp_t rq[$];
    wr_t   wq[$];
    rd_t   lq[$];

    function automatic void model_issue(bit we, logic [1:0] size, bit uns, int addr,
                                        logic [31:0] wdata, int acc, bit want);
        int n, ea;
        bit err;
        logic [31:0] v, d;
        logic [3:0] m;
        resp_t r;
        wr_t w;
        rd_t l;
        n   = (size == 2'd3) ? 4 : (1 << size);
        err = 1'b0;
`ifdef LSU_ERR_EN
        err = (size == 2'd3) || (addr % n != 0);
`endif
        ea = addr - addr % n;
        r.err = err; r.rdata = 32'd0; r.cyc = acc;
        if (!err && we) begin
            d = 32'd0; m = 4'd0;
            for (int i = 0; i < n; i++) model_mem[ea+i] = wdata[8*i +: 8];
            for (int k = 0; k < 4; k++) begin
                d[8*k +: 8] = wdata[8*(k % n) +: 8];
                if (k >= ea % 4 && k < ea % 4 + n) m[3-k] = 1'b1;
            end
            w.cyc = acc; w.addr = AW'(ea - ea % 4); w.data = d; w.mask = m;
            wq.push_back(w);
        end else if (!err) begin
            l.cyc = acc; l.addr = AW'(ea - ea % 4);
            lq.push_back(l);
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = model_mem[ea+i];
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            if (rd_resp_en) begin
                r.rdata = v; r.cyc = acc + 2;
            end else begin
                r.err = 1'b1; r.cyc = acc + 1 + TIMEOUT;
            end
        end
        if (want) rq.push_back(r);
    endfunction

    // Monitor: pops and compares whenever the DUT presents a strobe or response.
    resp_t mon_r;
    wr_t   mon_w;
    rd_t   mon_l;
    always @(negedge clk) begin
        if (mem_rd_en || mem_wr_en) check("strobe_overlap", 32'(mem_rd_en & mem_wr_en), 32'd0);
        if (mem_wr_en) begin
            if (wq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_wr addr=%h required=none", mem_addr);
            end else begin
                mon_w = wq.pop_front();
                check("wr_cycle", 32'(cyc), 32'(mon_w.cyc));
                check("wr_addr", 32'(mem_addr), 32'(mon_w.addr));
                check("wr_data", mem_wr_data, mon_w.data);
                check("wr_mask", 32'(mem_wr_mask), 32'(mon_w.mask));
            end
        end
        if (mem_rd_en) begin
            if (lq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rd addr=%h required=none", mem_addr);
            end else begin
                mon_l = lq.pop_front();
                check("rd_cycle", 32'(cyc), 32'(mon_l.cyc));
                check("rd_addr", 32'(mem_addr), 32'(mon_l.addr));
            end
        end
        if (resp_valid) begin
            $display("resp cyc=%0d rdata=%h err=%0d", cyc, resp_rdata, resp_err);
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_resp rdata=%h required=none", resp_rdata);
            end else begin
                mon_r = rq.pop_front();
                check("resp_cycle", 32'(cyc), 32'(mon_r.cyc));
                check("resp_rdata", resp_rdata, mon_r.rdata);
                check("resp_err", 32'(resp_err), 32'(mon_r.err));
            end
        end
    end

    // Holds the request stable until accepted; returns one ns after the accepting edge.
    task automatic do_req(input bit we, input logic [1:0] size, input bit uns, input int addr,
                          input logic [31:0] wdata, input bit want);
        int budget;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = AW'(addr); req_wdata = wdata;
        budget = 0;
        while (!req_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout ready=%0d required=1", req_ready);
            req_valid = 1'b0;
            return;
        end
        model_issue(we, size, uns, addr, wdata, cyc + 1, want);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    logic [31:0] w;
    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = 32'd0; rd_resp_en = 1'b1; inj_valid = 1'b0; inj_data = 32'd0;
        init_we = 1'b0; init_idx = 5'd0; init_word = 32'd0;

        for (int i = 0; i < SPAN/4; i++) begin
            @(negedge clk);
            w = (i == 0) ? 32'h0000_8000 : (i == 4) ? 32'hDEAD_BEEF : $urandom;
            init_we = 1'b1; init_idx = 5'(i); init_word = w;
            for (int j = 0; j < 4; j++) model_mem[4*i+j] = w[8*j +: 8];
        end
        @(negedge clk);
        init_we = 1'b0;

        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_wr_data", mem_wr_data, 32'd0);
        check("rst_wr_mask", 32'(mem_wr_mask), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // Directed cases from the test plan; the model supplies the expected values.
        do_req(1'b0, 2'd0, 1'b0, 1, 32'd0, 1'b1);
        do_req(1'b0, 2'd0, 1'b1, 1, 32'd0, 1'b1);
        do_req(1'b1, 2'd0, 1'b0, 6, 32'h0000_00A5, 1'b1);
        check("st_ready_t1", 32'(req_ready), 32'd1);
        check("st_wr_en_t1", 32'(mem_wr_en), 32'd1);
        check("st_resp_t1", 32'(resp_valid), 32'd1);
        do_req(1'b1, 2'd1, 1'b0, 2, 32'h0000_1234, 1'b1);
        do_req(1'b0, 2'd1, 1'b0, 2, 32'd0, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 16, 32'd0, 1'b1);
        check("ld_ready_t1", 32'(req_ready), 32'd0);
        check("ld_rd_en_t1", 32'(mem_rd_en), 32'd1);
        @(posedge clk); #1;
        check("ld_ready_t2", 32'(req_ready), 32'd0);
        check("ld_rd_en_t2", 32'(mem_rd_en), 32'd0);
        @(posedge clk); #1;
        check("ld_ready_t3", 32'(req_ready), 32'd1);
        check("ld_resp_t3", 32'(resp_valid), 32'd1);
        do_req(1'b1, 2'd2, 1'b0, 2, 32'h55AA_1234, 1'b1);
        check("wst_wr_en_t1", 32'(mem_wr_en), 32'(model_mem[0] == 8'h34));
`ifdef LSU_ERR_EN
        rd_resp_en = 1'b0;
        do_req(1'b0, 2'd2, 1'b0, 20, 32'd0, 1'b1);
        rd_resp_en = 1'b1;
        repeat (TIMEOUT + 4) @(negedge clk);
`endif

        // Reset while waiting for read data, then a stray mem_rd_valid.
        rd_resp_en = 1'b0;
        do_req(1'b0, 2'd2, 1'b0, 32, 32'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("wait_rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1; inj_valid = 1'b1; inj_data = 32'h1357_9BDF;
        @(negedge clk);
        inj_valid = 1'b0;
        rd_resp_en = 1'b1;
        check("wait_rst_ready_after", 32'(req_ready), 32'd1);
        check("wait_rst_strobes", 32'({mem_rd_en, mem_wr_en}), 32'd0);
        check("wait_rst_no_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("late_valid_no_resp", 32'(resp_valid), 32'd0);

        for (int t = 0; t < 200; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, SPAN - 1)), $urandom, 1'b1);
        end

        for (int i = 0; i < 100 && (rq.size() + wq.size() + lq.size()) != 0; i++) @(negedge clk);
        check("queues_drained", 32'(rq.size() + wq.size() + lq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
